// File: rtl/fib_alu_sequencer_pkg.sv
// Shared constants for the Fibonacci/ALU sequencer: ALU opcodes, flag bit
// positions and the sequencer state encoding.
package fib_alu_sequencer_pkg;

  localparam logic [7:0] ALU_OP_NOP = 8'b00000000;
  localparam logic [7:0] ALU_OP_ADD = 8'b00000101;

  localparam int unsigned FLAG_CARRY_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_ADD,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/fib_alu_sequencer.sv
// Sequences an external combinational ALU to stream Fibonacci terms F0..F(n-1)
// over a valid/ready port. Optional macro FIB_OVF_STOP_EN ends the run on carry.
module fib_alu_sequencer
  import fib_alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter logic [7:0]  OP_ADD    = ALU_OP_ADD,
  parameter int unsigned CARRY_BIT = FLAG_CARRY_BIT,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_index,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [7:0]       alu_opcode,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_c,
  input  logic [4:0]       alu_flags
);

  seq_state_t       state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] cur;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] count_nxt;
  logic             carry;
  logic             unused_flags;

  assign count_nxt    = count + 1'b1;
  assign carry        = alu_flags[CARRY_BIT];
  assign unused_flags = ^alu_flags;

  assign out_data  = cur;
  assign out_index = count;
  assign alu_a     = prev;
  assign alu_b     = cur;
  assign alu_cin   = 1'b0;

  // done/busy are registered out of DONE, so they change as the FSM returns to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prev       <= '0;
      cur        <= '0;
      count      <= '0;
      n_lat      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      alu_opcode <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_lat <= n_terms;
            prev  <= {{(WIDTH-1){1'b0}}, 1'b1};
            cur   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            if (n_terms == '0) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_EMIT;
              out_valid <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            count     <= count_nxt;
            if (count_nxt == n_lat) begin
              state <= ST_DONE;
            end else begin
              state      <= ST_ADD;
              alu_opcode <= OP_ADD;
            end
          end
        end
        ST_ADD: begin
          alu_opcode <= '0;
          prev       <= cur;
          cur        <= alu_c;
          if (carry) ovf <= 1'b1;
`ifdef FIB_OVF_STOP_EN
          if (carry) begin
            state <= ST_DONE;
          end else begin
            state     <= ST_EMIT;
            out_valid <= 1'b1;
          end
`else
          state     <= ST_EMIT;
          out_valid <= 1'b1;
`endif
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_alu_sequencer.sv
// Directed bench for fib_alu_sequencer with a behavioural adder standing in for the ALU.
module tb_fib_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  n_terms;
  logic        busy, done, ovf, out_valid, out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_index;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [7:0]  alu_opcode;
  logic        alu_cin;
  logic [4:0]  alu_flags;
  logic [16:0] alu_sum;

  int n_checks = 0;
  int n_fail   = 0;
  int fibm [64];
  int got  [64];
  int emitted, dones;

  always #5 clk = ~clk;

  fib_alu_sequencer #(.WIDTH(16), .OP_ADD(8'h05), .CARRY_BIT(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
    .busy(busy), .done(done), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_c(alu_c), .alu_flags(alu_flags)
  );

  assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_c     = (alu_opcode == 8'h05) ? alu_sum[15:0] : 16'h0000;
  assign alu_flags = {1'b0, (alu_opcode == 8'h05) && alu_sum[16], 3'b000};

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic kick(input int n);
    start   = 1'b1;
    n_terms = 8'(n);
    step();
    start   = 1'b0;
  endtask

  task automatic collect(input int budget);
    emitted = 0;
    dones   = 0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        dones++;
        break;
      end
      if (out_valid && out_ready) begin
        chk("term_data", int'(out_data), fibm[emitted]);
        chk("term_index", int'(out_index), emitted);
        got[emitted] = int'(out_data);
        emitted++;
      end
      step();
    end
    chk("done_seen", dones, 1);
  endtask

  initial begin
    fibm[0] = 0;
    fibm[1] = 1;
    for (int i = 2; i < 64; i++) fibm[i] = (fibm[i-1] + fibm[i-2]) % 65536;

    rst_n = 1'b0; start = 1'b0; n_terms = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_cin", alu_cin, 0);
    rst_n = 1'b1;
    step();

    // basic sequence, 2 cycles per term
    kick(8);
    begin
      int exp8 [8] = '{0, 1, 1, 2, 3, 5, 8, 13};
      for (int k = 0; k < 8; k++) begin
        chk("basic_valid", out_valid, 1);
        chk("basic_data", out_data, exp8[k]);
        chk("basic_index", out_index, k);
        chk("basic_op_emit", alu_opcode, 0);
        step();
        if (k < 7) begin
          chk("add_valid", out_valid, 0);
          chk("add_opcode", alu_opcode, 8'h05);
          step();
        end
      end
    end
    chk("basic_done_wait", done, 0);
    chk("basic_busy_wait", busy, 1);
    step();
    chk("basic_done", done, 1);
    chk("basic_busy_end", busy, 0);
    chk("basic_ovf", ovf, 0);
    step();
    chk("basic_done_pulse", done, 0);

    // backpressure on index 2
    kick(4);
    for (int k = 0; k < 4; k++) begin
      chk("bp_data", out_data, fibm[k]);
      chk("bp_index", out_index, k);
      if (k == 2) begin
        out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
          step();
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_hold_data", out_data, 1);
          chk("bp_hold_index", out_index, 2);
        end
        out_ready = 1'b1;
      end
      step();
      if (k < 3) step();
    end
    step();
    chk("bp_done", done, 1);
    step();

    // zero terms
    kick(0);
    chk("zero_valid", out_valid, 0);
    chk("zero_busy", busy, 1);
    chk("zero_done_early", done, 0);
    step();
    chk("zero_done", done, 1);
    chk("zero_valid2", out_valid, 0);
    step();

    // start while busy is ignored
    kick(5);
    start = 1'b1;
    n_terms = 8'd2;
    collect(100);
    start = 1'b0;
    chk("busy_start_count", emitted, 5);
    chk("busy_start_idle", busy, 0);
    step();
    chk("busy_start_norestart", busy, 0);

    // reset during ADD
    kick(8);
    step();
    chk("mid_in_add", alu_opcode, 8'h05);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_opcode", alu_opcode, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_index", out_index, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int h = 0; h < 4; h++) begin
      step();
      chk("mid_no_done", done, 0);
    end
    kick(3);
    collect(100);
    chk("mid_fresh_count", emitted, 3);
    step();

    // 16-bit overflow
`ifdef FIB_OVF_STOP_EN
    kick(30);
    collect(200);
    chk("ovf_stop_count", emitted, 25);
    chk("ovf_stop_last", got[24], 46368);
    chk("ovf_stop_flag", ovf, 1);
`else
    kick(27);
    collect(200);
    chk("ovf_wrap_count", emitted, 27);
    chk("ovf_wrap_f24", got[24], 46368);
    chk("ovf_wrap_f25", got[25], 9489);
    chk("ovf_wrap_f26", got[26], 55857);
    chk("ovf_wrap_flag", ovf, 1);
`endif
    step();
    kick(2);
    chk("ovf_clear_on_start", ovf, 0);
    collect(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fib_alu_sequencer.md
Name: fib_alu_sequencer

Overview:
- Clocked controller that sequences the shared combinational ALU (A/B/C/Cin/Opcode/Flags datapath) to generate Fibonacci terms F0..F(n-1).
- Sits between a requester (start/n_terms) and the ALU. Owns the ALU operand/opcode lines while busy.
- Streams each term out over a valid/ready handshake.
- Reports completion and 16-bit carry overflow.

Parameters:
- WIDTH, 16, datapath width (ALU A/B/C width)
- OP_ADD, 8'b00000101, ALU opcode driven for addition
- CARRY_BIT, 3, index of the carry flag within Flags[4:0]
- CNT_W, 8, width of n_terms/out_index

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- n_terms  in  CNT_W  number of terms to emit; latched on accepted start
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle completion pulse
- ovf  out  1  sticky carry-overflow indicator; cleared on accepted start
- out_valid  out  1  term available
- out_ready  in  1  consumer accepts term
- out_data  out  WIDTH  current term value
- out_index  out  CNT_W  index k of out_data (F_k)
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_opcode  out  8  ALU opcode
- alu_cin  out  1  ALU carry-in, always 0
- alu_c  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_opcode)
- alu_flags  in  5  ALU flags

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - Outputs: busy=0, done=0, ovf=0, out_valid=0, out_data=0, out_index=0, alu_a=0, alu_b=0, alu_opcode=0, alu_cin=0.
  - Internal registers: prev=0, cur=0, count=0.
- Internal registers: prev and cur (WIDTH bits) and count (CNT_W bits). out_data=cur, out_index=count, alu_a=prev, alu_b=cur.
- States: IDLE, EMIT, ADD, DONE.
- IDLE:
  - start=1 latches n_terms and sets prev=1 (F(-1) seed), cur=0, count=0, ovf=0, busy=1.
  - Next state is EMIT, or DONE if n_terms=0 (no terms emitted).
- EMIT:
  - out_valid=1. out_data/out_index are held stable until the handshake.
  - When out_valid&&out_ready: count<=count+1. Next state is DONE if count+1==latched n, else ADD.
- ADD (exactly 1 cycle):
  - alu_opcode=OP_ADD. ALU result is captured at the end of the cycle: prev<=cur, cur<=alu_c.
  - If alu_flags[CARRY_BIT]=1, set ovf=1.
  - Next state is EMIT (see the optional feature for termination on overflow).
  - Outside ADD, alu_opcode=0.
- DONE: done=1 for one cycle, busy=0 on exit, then IDLE.
- Throughput: 2 cycles per term with out_ready held high. Latency from start to the first out_valid is 1 cycle.
- start while busy is ignored. n_terms changes while busy are ignored.
- Reset asserted mid-sequence aborts immediately to reset values; no done pulse is produced.
- Index arithmetic: count wraps only beyond n_terms, which cannot occur, so no wrap handling is required.
- Term arithmetic is modulo 2^WIDTH.
- Boundary: the last in-range 16-bit term is F24=46368. Computing F25 asserts carry.

Optional Feature:
- Macro: FIB_OVF_STOP_EN.
- Defined: a carry in ADD sets ovf=1 and the next state is DONE instead of EMIT. The overflowed term is never emitted, and done pulses normally.
- Undefined: ovf is still set (sticky), but sequencing continues with wrapped values until n_terms are emitted.

Decomposition:
- Shared package holds:
  - ALU opcode constants, including OP_ADD=8'b00000101.
  - Flag bit index constants, including CARRY_BIT=3.
  - The sequencer state encoding (IDLE/EMIT/ADD/DONE).
- No sub-module. The ALU is external and instantiated alongside this block at top level; the single FSM plus registers does not warrant splitting.

Test Plan:
- Reset mid-run: rst_n pulsed low during ADD -> all outputs 0 immediately, state IDLE, no done; a fresh start afterwards runs correctly.
- Basic sequence: start with n_terms=8, out_ready=1 -> out_data 0,1,1,2,3,5,8,13 at index 0..7, 2 cycles apart. One done pulse, ovf=0, alu_opcode=8'h05 only in ADD cycles.
- Backpressure: n_terms=4, out_ready low for 5 cycles on term index 2 -> out_data=1 and out_index=2 held stable. Sequence 0,1,1,2 is unchanged.
- Zero/busy start: n_terms=0 -> done pulse 2 cycles after start with no out_valid. A second start during a run with n_terms=5 is ignored.
- Overflow with FIB_OVF_STOP_EN defined: n_terms=30 -> 25 terms emitted, last value 46368 (index 24), then ovf=1 and done.
- Overflow without FIB_OVF_STOP_EN: n_terms=27 -> index 25 = 9489 (75025 mod 65536), index 26 = 55857, ovf=1, 27 terms emitted.
